// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_pkg
// Description : Shared definitions for the writeback / load path: load funct3
//               encodings and the writeback state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_pkg;

   // Load funct3 encodings
   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   // Writeback state encoding
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_MEM = 2'd1,
      WRITE_LD = 2'd2
   } wb_state_t;

endpackage
`default_nettype wire

// File: rtl/rv_writeback_if.sv
`default_nettype none
// ============================================================================
// Module      : rv_writeback_if
// Description : Bundle of the ALU result, load issue, memory return, hazard
//               query and register-file write signals around the writeback
//               stage. master = surrounding pipeline, slave = writeback stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface rv_writeback_if;

   logic        alu_valid;
   logic [4:0]  alu_rda;
   logic [31:0] alu_rd;
   logic        ld_req;
   logic [4:0]  ld_rda;
   logic [2:0]  ld_funct3;
   logic [1:0]  ld_addr_lo;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic [4:0]  rs1a;
   logic [4:0]  rs2a;
   logic        stall;
   logic        ld_busy;
   logic [4:0]  rda;
   logic [31:0] rd;
   logic        rdw;
   logic        err;

   modport master (
      output alu_valid, alu_rda, alu_rd,
      output ld_req, ld_rda, ld_funct3, ld_addr_lo,
      output mem_rvalid, mem_rdata,
      output rs1a, rs2a,
      input  stall, ld_busy, rda, rd, rdw, err
   );

   modport slave (
      input  alu_valid, alu_rda, alu_rd,
      input  ld_req, ld_rda, ld_funct3, ld_addr_lo,
      input  mem_rvalid, mem_rdata,
      input  rs1a, rs2a,
      output stall, ld_busy, rda, rd, rdw, err
   );

endinterface
`default_nettype wire

// File: rtl/rv_load_align.sv
`default_nettype none
// ============================================================================
// Module      : rv_load_align
// Description : Combinational load data aligner. Selects the addressed byte or
//               halfword from a word-aligned memory word and sign/zero-extends
//               it according to funct3. Unknown funct3 yields 0 and a flag.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_load_align
   import rv_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] mem_rdata,
   output logic [31:0] value,
   output logic        bad_funct3
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the addressed byte and halfword lanes out of the memory word
   always_comb begin
      byte_sel = mem_rdata[7:0];
      case (addr_lo)
         2'd0: byte_sel = mem_rdata[7:0];
         2'd1: byte_sel = mem_rdata[15:8];
         2'd2: byte_sel = mem_rdata[23:16];
         2'd3: byte_sel = mem_rdata[31:24];
         default: byte_sel = mem_rdata[7:0];
      endcase
      half_sel = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
   end

   // Extend the selected lane; LW ignores addr_lo and passes the word through
   always_comb begin
      value      = 32'd0;
      bad_funct3 = 1'b0;
      case (funct3)
         LB:      value = {{24{byte_sel[7]}}, byte_sel};
         LH:      value = {{16{half_sel[15]}}, half_sel};
         LW:      value = mem_rdata;
         LBU:     value = {24'd0, byte_sel};
         LHU:     value = {16'd0, half_sel};
         default: begin
            value      = 32'd0;
            bad_funct3 = 1'b1;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/rv_writeback.sv
`default_nettype none
// ============================================================================
// Module      : rv_writeback
// Description : Writeback stage in front of the register file. Merges ALU
//               results with a single outstanding load onto one write port,
//               aligns/extends load data, and raises a load-use stall.
//               ERR_STICKY = "TRUE"  : err holds until reset
//               ERR_STICKY = "FALSE" : err pulses one cycle per error
// Revision    : 1.0 - initial release
// ============================================================================
module rv_writeback
   import rv_pkg::*;
#(
   parameter ERR_STICKY = "TRUE"
)
(
   input  logic          clk,
   input  logic          rst_n,
   rv_writeback_if.slave bus
);

   wb_state_t   state_q, state_d;
   logic [4:0]  ld_rda_q, ld_rda_d;
   logic [2:0]  ld_funct3_q, ld_funct3_d;
   logic [1:0]  ld_addr_lo_q, ld_addr_lo_d;
   logic [31:0] buf_q, buf_d;
   logic [4:0]  rda_q, rda_d;
   logic [31:0] rd_q, rd_d;
   logic        rdw_q, rdw_d;
   logic        err_q, err_d;

   logic        wr_en;
   logic [4:0]  wr_rda;
   logic [31:0] wr_data;
   logic        err_evt;
   logic [31:0] ld_value;
   logic        ld_bad;

   // Extraction always uses the latched load attributes, since the request
   // inputs belong to whatever decode is issuing now, not the returning load.
   rv_load_align u_load_align (
      .funct3     (ld_funct3_q),
      .addr_lo    (ld_addr_lo_q),
      .mem_rdata  (bus.mem_rdata),
      .value      (ld_value),
      .bad_funct3 (ld_bad)
   );

   // Next-state, write-port arbitration and error event detection
   always_comb begin
      state_d      = state_q;
      ld_rda_d     = ld_rda_q;
      ld_funct3_d  = ld_funct3_q;
      ld_addr_lo_d = ld_addr_lo_q;
      buf_d        = buf_q;
      wr_en        = 1'b0;
      wr_rda       = rda_q;
      wr_data      = rd_q;
      err_evt      = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.alu_valid) begin
               wr_en   = 1'b1;
               wr_rda  = bus.alu_rda;
               wr_data = bus.alu_rd;
            end
            if (bus.ld_req) begin
               ld_rda_d     = bus.ld_rda;
               ld_funct3_d  = bus.ld_funct3;
               ld_addr_lo_d = bus.ld_addr_lo;
               state_d      = WAIT_MEM;
            end
            // No load outstanding, so returned data has no owner
            if (bus.mem_rvalid) begin
               err_evt = 1'b1;
            end
         end

         WAIT_MEM: begin
            // Only one load may be outstanding; the extra request is dropped
            if (bus.ld_req) begin
               err_evt = 1'b1;
            end
            if (bus.mem_rvalid) begin
               if (ld_bad) begin
                  err_evt = 1'b1;
               end
               if (bus.alu_valid) begin
                  // ALU owns the port this cycle; park the load for next cycle
                  wr_en   = 1'b1;
                  wr_rda  = bus.alu_rda;
                  wr_data = bus.alu_rd;
                  buf_d   = ld_value;
                  state_d = WRITE_LD;
               end else begin
                  wr_en   = 1'b1;
                  wr_rda  = ld_rda_q;
                  wr_data = ld_value;
                  state_d = IDLE;
               end
            end else if (bus.alu_valid) begin
               wr_en   = 1'b1;
               wr_rda  = bus.alu_rda;
               wr_data = bus.alu_rd;
            end
         end

         WRITE_LD: begin
            // Decode is stalled here, so any ALU result is not accepted
            wr_en   = 1'b1;
            wr_rda  = ld_rda_q;
            wr_data = buf_q;
            state_d = IDLE;
            if (bus.mem_rvalid || bus.ld_req) begin
               err_evt = 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // x0 is hardwired zero: keep the data path moving but never enable it
      rda_d = wr_rda;
      rd_d  = wr_data;
      rdw_d = wr_en && (wr_rda != 5'd0);
   end

   generate
      if (ERR_STICKY == "TRUE") begin : g_err_sticky
         assign err_d = err_q | err_evt;
      end else begin : g_err_pulse
         assign err_d = err_evt;
      end
   endgenerate

   // State, load buffer and registered write-port outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         ld_rda_q     <= 5'd0;
         ld_funct3_q  <= 3'd0;
         ld_addr_lo_q <= 2'd0;
         buf_q        <= 32'd0;
         rda_q        <= 5'd0;
         rd_q         <= 32'd0;
         rdw_q        <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         ld_rda_q     <= ld_rda_d;
         ld_funct3_q  <= ld_funct3_d;
         ld_addr_lo_q <= ld_addr_lo_d;
         buf_q        <= buf_d;
         rda_q        <= rda_d;
         rd_q         <= rd_d;
         rdw_q        <= rdw_d;
         err_q        <= err_d;
      end
   end

   // Load-use hazard: hold decode while a read would see a stale register
   assign bus.stall   = (state_q == WRITE_LD) ||
                        ((state_q == WAIT_MEM) && (ld_rda_q != 5'd0) &&
                         ((bus.rs1a == ld_rda_q) || (bus.rs2a == ld_rda_q)));
   assign bus.ld_busy = (state_q != IDLE);
   assign bus.rda     = rda_q;
   assign bus.rd      = rd_q;
   assign bus.rdw     = rdw_q;
   assign bus.err     = err_q;

endmodule
`default_nettype wire
